// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
// The controller states and the byte-mask expansion used by the lane-merge write path.
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    function automatic logic [WORD_BYTES*BYTE_W-1:0] mask_to_bits(input logic [WORD_BYTES-1:0] mask);
        logic [WORD_BYTES*BYTE_W-1:0] bits;
        bits = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            bits[i*BYTE_W +: BYTE_W] = {BYTE_W{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_ws_ctrl.sv
// Request/response sequencer for dmem_ws: IDLE -> (WAIT) -> RESP with a wait-state counter.
// Handshake: a request is taken on any rising edge where req && ready; valid pulses one cycle per request.
module dmem_ws_ctrl
    import dmem_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ready,
    output logic        valid,
    output logic        accept,
    output logic        sample,
    output dmem_state_e state_o,
    output logic [3:0]  wait_cnt_o
);

    localparam int          WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WS_INIT = WS_M1[3:0];
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        valid   = 1'b0;
        accept  = 1'b0;
        sample  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                ready = 1'b1;
                valid = (state_q == RESP);
                if (req) begin
                    accept = 1'b1;
                    // With no wait states the response data is latched at the accept edge itself.
                    if (NO_WAIT) begin
                        state_d = RESP;
                        sample  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    sample  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_o    = state_q;
    assign wait_cnt_o = cnt_q;

endmodule

// File: rtl/dmem_ws.sv
// Byte-addressed, word-organised data memory with byte-lane writes, registered reads,
// configurable wait states and a single-outstanding ready/valid request-response port.
module dmem_ws
    import dmem_pkg::*;
#(
    parameter int SIZE_IN_BYTES = 1024,
    parameter int WAIT_STATES   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_ready,
    output logic        op_data_valid,
    output logic [31:0] op_data_from_dmem,
    output logic        op_data_err
);

    localparam int AW    = $clog2(SIZE_IN_BYTES);
    localparam int DEPTH = SIZE_IN_BYTES / WORD_BYTES;

    logic        accept, sample;
    dmem_state_e dbg_state;
    logic [3:0]  dbg_wait_cnt;

    dmem_ws_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .req        (ip_data_rd | ip_data_wr),
        .ready      (op_data_ready),
        .valid      (op_data_valid),
        .accept     (accept),
        .sample     (sample),
        .state_o    (dbg_state),
        .wait_cnt_o (dbg_wait_cnt)
    );

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] addr_q, addr_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          misaligned;
    logic          mem_we;
    logic [31:0]   bit_en;

    // The _d values double as "the request being serviced", so a zero-wait read sees the live inputs.
    always_comb begin
        addr_d     = accept ? ip_data_addr[AW-1:0] : addr_q;
        is_wr_d    = accept ? ip_data_wr : is_wr_q;
        misaligned = (addr_d[1:0] != 2'b00);
        mem_we     = accept && ip_data_wr && (ip_data_addr[1:0] == 2'b00) && !rst;
        bit_en     = mask_to_bits(ip_data_mask);
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (sample) begin
            err_d   = misaligned;
            rdata_d = (is_wr_d || misaligned) ? 32'd0 : mem_q[addr_d[AW-1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; writes commit at the accept edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ip_data_addr[AW-1:2]] <= (mem_q[ip_data_addr[AW-1:2]] & ~bit_en)
                                         | (ip_data_from_proc & bit_en);
        end
    end

    assign op_data_from_dmem = rdata_q;
    assign op_data_err       = err_q;

    logic unused_ok;
    assign unused_ok = ^{ip_data_addr[31:AW], dbg_state, dbg_wait_cnt};

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws: one instance per WAIT_STATES value 0..3, each driven in turn.
module tb_dmem_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [4];
    logic [31:0] addr_s  [4];
    logic        wr_s    [4];
    logic [3:0]  mask_s  [4];
    logic [31:0] wdata_s [4];
    logic        rd_s    [4];
    logic        ready_s [4];
    logic        valid_s [4];
    logic [31:0] rdata_s [4];
    logic        err_s   [4];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_ws #(
            .SIZE_IN_BYTES (256),
            .WAIT_STATES   (g)
        ) u_dut (
            .clk               (clk),
            .rst               (rst_s[g]),
            .ip_data_addr      (addr_s[g]),
            .ip_data_wr        (wr_s[g]),
            .ip_data_mask      (mask_s[g]),
            .ip_data_from_proc (wdata_s[g]),
            .ip_data_rd        (rd_s[g]),
            .op_data_ready     (ready_s[g]),
            .op_data_valid     (valid_s[g]),
            .op_data_from_dmem (rdata_s[g]),
            .op_data_err       (err_s[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k (whose wait-state count equals k).
    task automatic req(input int k, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic [31:0] exp_d, input logic exp_e, input string tag);
        int n;
        @(negedge clk);
        rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; wdata_s[k] = d; mask_s[k] = m;
        chk({tag, "_ready"}, {31'd0, ready_s[k]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
        n = 1;
        while (valid_s[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, k + 1);
        chk({tag, "_data"}, rdata_s[k], exp_d);
        chk({tag, "_err"}, {31'd0, err_s[k]}, {31'd0, exp_e});
        @(negedge clk);
        chk({tag, "_valid_drop"}, {31'd0, valid_s[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int i = 0; i < 4; i++) begin
            rst_s[i] = 1'b1; addr_s[i] = '0; wr_s[i] = 1'b0; mask_s[i] = '0;
            wdata_s[i] = '0; rd_s[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) rst_s[i] = 1'b0;

        chk("rst_ready", {31'd0, ready_s[1]}, 32'd1);
        chk("rst_valid", {31'd0, valid_s[1]}, 32'd0);
        chk("rst_data", rdata_s[1], 32'd0);
        chk("rst_err", {31'd0, err_s[3]}, 32'd0);

        // WAIT_STATES=1: full write/read, masked write, misaligned accesses.
        req(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, "ws1_wr");
        req(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "ws1_rd");
        req(1, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'd0, 1'b0, "ws1_mwr");
        req(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, "ws1_mrd");
        req(1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'd0, 1'b0, "ws1_nomask");
        req(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, "ws1_nomask_rd");
        req(1, 1'b1, 1'b0, 32'h13, 32'd0, 4'h0, 32'd0, 1'b1, "ws1_misrd");
        req(1, 1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, "ws1_miswr");
        req(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, "ws1_after_mis");
        req(1, 1'b1, 1'b0, 32'h110, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, "ws1_wrap");

        // WAIT_STATES=0: back-to-back reads with rd held high.
        req(0, 1'b0, 1'b1, 32'h0, 32'd1, 4'hF, 32'd0, 1'b0, "ws0_pre0");
        req(0, 1'b0, 1'b1, 32'h4, 32'd2, 4'hF, 32'd0, 1'b0, "ws0_pre1");
        req(0, 1'b0, 1'b1, 32'h8, 32'd3, 4'hF, 32'd0, 1'b0, "ws0_pre2");
        @(negedge clk);
        rd_s[0] = 1'b1; addr_s[0] = 32'h0;
        chk("ws0_b2b_ready0", {31'd0, ready_s[0]}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk("ws0_b2b_valid1", {31'd0, valid_s[0]}, 32'd1);
        chk("ws0_b2b_data1", rdata_s[0], 32'd1);
        chk("ws0_b2b_ready1", {31'd0, ready_s[0]}, 32'd1);
        addr_s[0] = 32'h4;
        @(posedge clk); @(negedge clk);
        chk("ws0_b2b_valid2", {31'd0, valid_s[0]}, 32'd1);
        chk("ws0_b2b_data2", rdata_s[0], 32'd2);
        chk("ws0_b2b_ready2", {31'd0, ready_s[0]}, 32'd1);
        addr_s[0] = 32'h8;
        @(posedge clk); @(negedge clk);
        chk("ws0_b2b_valid3", {31'd0, valid_s[0]}, 32'd1);
        chk("ws0_b2b_data3", rdata_s[0], 32'd3);
        rd_s[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ws0_b2b_end", {31'd0, valid_s[0]}, 32'd0);

        // WAIT_STATES=3: reset during the wait window.
        req(3, 1'b0, 1'b1, 32'h20, 32'd0, 4'hF, 32'd0, 1'b0, "ws3_clear");
        @(negedge clk);
        wr_s[3] = 1'b1; addr_s[3] = 32'h20; wdata_s[3] = 32'hA5A5A5A5; mask_s[3] = 4'hF;
        @(posedge clk); @(negedge clk);
        wr_s[3] = 1'b0;
        chk("ws3_busy", {31'd0, ready_s[3]}, 32'd0);
        @(posedge clk); @(negedge clk);
        rst_s[3] = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ws3_rst_ready", {31'd0, ready_s[3]}, 32'd1);
        chk("ws3_rst_valid", {31'd0, valid_s[3]}, 32'd0);
        chk("ws3_rst_data", rdata_s[3], 32'd0);
        chk("ws3_rst_err", {31'd0, err_s[3]}, 32'd0);
        rst_s[3] = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_s[3] === 1'b1) seen++;
        end
        chk("ws3_no_pulse", seen, 0);
        req(3, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, "ws3_rd");

        // WAIT_STATES=2: rd+wr together, and a request raised while not ready.
        @(negedge clk);
        rd_s[2] = 1'b1; wr_s[2] = 1'b1; addr_s[2] = 32'h30; wdata_s[2] = 32'h5; mask_s[2] = 4'hF;
        @(posedge clk); @(negedge clk);
        chk("ws2_busy0", {31'd0, ready_s[2]}, 32'd0);
        wr_s[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ws2_busy1", {31'd0, ready_s[2]}, 32'd0);
        chk("ws2_novalid", {31'd0, valid_s[2]}, 32'd0);
        rd_s[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ws2_ack_valid", {31'd0, valid_s[2]}, 32'd1);
        chk("ws2_ack_data", rdata_s[2], 32'd0);
        chk("ws2_ack_err", {31'd0, err_s[2]}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid_s[2] === 1'b1) seen++;
        end
        chk("ws2_no_extra", seen, 0);
        req(2, 1'b1, 1'b0, 32'h30, 32'd0, 4'h0, 32'h5, 1'b0, "ws2_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
